// File: rtl/csc_pkg.sv
// Shared defaults and arithmetic helpers for the csc_nxn colour-space converter
// and its per-channel csc_dot sub-module.
package csc_pkg;

    localparam int CSC_CH          = 3;
    localparam int CSC_DATA_WIDTH  = 8;
    localparam int CSC_COEF_WIDTH  = 10;
    localparam int CSC_FRAC_BITS   = 8;
    localparam int CSC_BIAS_WIDTH  = 8;
    localparam int CSC_ID_MAX_BITS = 4096;
    localparam int CSC_CLAMP_BITS  = 64;

    typedef enum logic [1:0] {
        CLAMP_NONE = 2'd0,
        CLAMP_LOW  = 2'd1,
        CLAMP_HIGH = 2'd2
    } clamp_e;

    function automatic int csc_acc_width(int data_width, int coef_width, int ch);
        return data_width + coef_width + $clog2(ch) + 1;
    endfunction

    // Flat CHxCH coefficient vector with 1.0 on the diagonal; callers slice the low bits.
    function automatic logic [CSC_ID_MAX_BITS-1:0] csc_identity(int ch, int coef_width, int frac_bits);
        logic [CSC_ID_MAX_BITS-1:0] id;
        id = '0;
        for (int r = 0; r < ch; r++)
            id[(r * ch + r) * coef_width + frac_bits] = 1'b1;
        return id;
    endfunction

    function automatic clamp_e csc_clamp(logic signed [CSC_CLAMP_BITS-1:0] v, int data_width);
        logic signed [CSC_CLAMP_BITS-1:0] max_val;
        max_val = (64'sd1 <<< data_width) - 64'sd1;
        if (v < 0)
            return CLAMP_LOW;
        else if (v > max_val)
            return CLAMP_HIGH;
        else
            return CLAMP_NONE;
    endfunction

endpackage

// File: rtl/csc_dot.sv
// One output channel of csc_nxn: CH products, row sum with rounding, bias add
// and clamp over three register stages; bypass and bias travel with the data.
module csc_dot
    import csc_pkg::*;
#(
    parameter int CH         = CSC_CH,
    parameter int DATA_WIDTH = CSC_DATA_WIDTH,
    parameter int COEF_WIDTH = CSC_COEF_WIDTH,
    parameter int FRAC_BITS  = CSC_FRAC_BITS,
    parameter int BIAS_WIDTH = CSC_BIAS_WIDTH,
    parameter int ROW        = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CH*COEF_WIDTH-1:0]       coef_row,
    input  logic [BIAS_WIDTH-1:0]          bias,
    input  logic                           bypass,
    input  logic [CH*DATA_WIDTH-1:0]       x,
    output logic [DATA_WIDTH-1:0]          y,
    output logic                           sat
);

    localparam int AW = csc_acc_width(DATA_WIDTH, COEF_WIDTH, CH);
    localparam int PW = DATA_WIDTH + COEF_WIDTH + 1;
    localparam int YW = AW + 1;
    localparam logic signed [AW-1:0] HALF = (FRAC_BITS > 0) ? (AW'(1) << (FRAC_BITS - 1)) : AW'(0);

    logic signed [PW-1:0]         s1_prod [CH];
    logic signed [BIAS_WIDTH-1:0] s1_bias, s2_bias;
    logic                         s1_bypass, s2_bypass;
    logic [DATA_WIDTH-1:0]        s1_raw, s2_raw;
    logic signed [AW-1:0]         s2_rnd;
    logic signed [AW-1:0]         acc;
    logic signed [YW-1:0]         y_full;
    clamp_e                       clamp_sel;

    // NOTE: combinational logic uses blocking '=' so the loop accumulates in order
    // within one evaluation; defaults first keep it latch-free.
    always_comb begin
        acc = HALF;
        for (int c = 0; c < CH; c++)
            acc = acc + AW'(s1_prod[c]);
        y_full    = YW'(s2_rnd) + YW'(s2_bias);
        clamp_sel = csc_clamp(CSC_CLAMP_BITS'(y_full), DATA_WIDTH);
    end

    // NOTE: state uses non-blocking '<=' so every stage samples the previous
    // stage's old value on the same edge; the small product array is reset too,
    // keeping don't-care outputs free of X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CH; c++)
                s1_prod[c] <= '0;
            s1_bias   <= '0;
            s1_bypass <= 1'b0;
            s1_raw    <= '0;
            s2_rnd    <= '0;
            s2_bias   <= '0;
            s2_bypass <= 1'b0;
            s2_raw    <= '0;
            y         <= '0;
            sat       <= 1'b0;
        end else begin
            for (int c = 0; c < CH; c++)
                s1_prod[c] <= PW'($signed(coef_row[c*COEF_WIDTH +: COEF_WIDTH]))
                            * $signed(PW'(x[c*DATA_WIDTH +: DATA_WIDTH]));
            s1_bias   <= bias;
            s1_bypass <= bypass;
            s1_raw    <= x[ROW*DATA_WIDTH +: DATA_WIDTH];

            s2_rnd    <= acc >>> FRAC_BITS;
            s2_bias   <= s1_bias;
            s2_bypass <= s1_bypass;
            s2_raw    <= s1_raw;

            if (s2_bypass) begin
                y   <= s2_raw;
                sat <= 1'b0;
            end else begin
                case (clamp_sel)
                    CLAMP_LOW:  begin y <= '0; sat <= 1'b1; end
                    CLAMP_HIGH: begin y <= '1; sat <= 1'b1; end
                    default:    begin y <= y_full[DATA_WIDTH-1:0]; sat <= 1'b0; end
                endcase
            end
        end
    end

endmodule

// File: rtl/csc_nxn.sv
// N-channel matrix-multiply-plus-bias colour-space converter with frame-boundary
// double buffering. Optional CSC_SAT_CNT_EN adds a per-frame clamp counter (o_sat_cnt).
module csc_nxn
    import csc_pkg::*;
#(
    parameter int CH         = CSC_CH,
    parameter int DATA_WIDTH = CSC_DATA_WIDTH,
    parameter int COEF_WIDTH = CSC_COEF_WIDTH,
    parameter int FRAC_BITS  = CSC_FRAC_BITS,
    parameter int BIAS_WIDTH = CSC_BIAS_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CH*CH*COEF_WIDTH-1:0]   i_coef,
    input  logic [CH*BIAS_WIDTH-1:0]      i_bias,
    input  logic                          i_bypass,
    input  logic                          i_vs,
    input  logic                          i_hs,
    input  logic                          i_de,
    input  logic [CH*DATA_WIDTH-1:0]      i_x,
    output logic                          o_vs,
    output logic                          o_hs,
    output logic                          o_de,
    output logic [CH*DATA_WIDTH-1:0]      o_y,
    output logic                          o_cfg_upd
`ifdef CSC_SAT_CNT_EN
    ,
    output logic [15:0]                   o_sat_cnt
`endif
);

    localparam logic [CSC_ID_MAX_BITS-1:0]    ID_FULL    = csc_identity(CH, COEF_WIDTH, FRAC_BITS);
    localparam logic [CH*CH*COEF_WIDTH-1:0]   COEF_RESET = ID_FULL[CH*CH*COEF_WIDTH-1:0];

    logic [CH*CH*COEF_WIDTH-1:0] act_coef;
    logic [CH*BIAS_WIDTH-1:0]    act_bias;
    logic                        act_bypass;
    logic                        vs_q;
    logic                        vs_rise;
    logic [2:0]                  sync_pipe [3];
    logic [CH-1:0]               ch_sat;

    // The active set changes at the end of the vs-rise cycle, so that cycle's pixel still sees the old set.
    assign vs_rise = i_vs & ~vs_q;
    assign {o_vs, o_hs, o_de} = sync_pipe[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_coef   <= COEF_RESET;
            act_bias   <= '0;
            act_bypass <= 1'b0;
            vs_q       <= 1'b0;
            o_cfg_upd  <= 1'b0;
            for (int i = 0; i < 3; i++)
                sync_pipe[i] <= '0;
        end else begin
            vs_q      <= i_vs;
            o_cfg_upd <= vs_rise;
            if (vs_rise) begin
                act_coef   <= i_coef;
                act_bias   <= i_bias;
                act_bypass <= i_bypass;
            end
            sync_pipe[0] <= {i_vs, i_hs, i_de};
            sync_pipe[1] <= sync_pipe[0];
            sync_pipe[2] <= sync_pipe[1];
        end
    end

    for (genvar r = 0; r < CH; r++) begin : g_row
        csc_dot #(
            .CH         (CH),
            .DATA_WIDTH (DATA_WIDTH),
            .COEF_WIDTH (COEF_WIDTH),
            .FRAC_BITS  (FRAC_BITS),
            .BIAS_WIDTH (BIAS_WIDTH),
            .ROW        (r)
        ) u_dot (
            .clk      (clk),
            .rst      (rst),
            .coef_row (act_coef[r*CH*COEF_WIDTH +: CH*COEF_WIDTH]),
            .bias     (act_bias[r*BIAS_WIDTH +: BIAS_WIDTH]),
            .bypass   (act_bypass),
            .x        (i_x),
            .y        (o_y[r*DATA_WIDTH +: DATA_WIDTH]),
            .sat      (ch_sat[r])
        );
    end

`ifdef CSC_SAT_CNT_EN
    logic [15:0] sat_cnt;
    logic        o_vs_q;
    logic        sat_hit;

    // ch_sat is already forced low in bypass, so only processed pixels count.
    assign sat_hit = o_de & (|ch_sat);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_cnt   <= '0;
            o_sat_cnt <= '0;
            o_vs_q    <= 1'b0;
        end else begin
            o_vs_q <= o_vs;
            if (o_vs & ~o_vs_q) begin
                o_sat_cnt <= sat_cnt;
                sat_cnt   <= 16'(sat_hit);
            end else if (sat_hit && sat_cnt != 16'hFFFF) begin
                sat_cnt <= sat_cnt + 16'd1;
            end
        end
    end
`else
    logic unused_sat;
    assign unused_sat = |ch_sat;
`endif

endmodule

// File: tb/tb_csc_nxn.sv
// Scoreboard bench for csc_nxn: stimulus pushes hand-computed pixels, a monitor
// pops and compares on every o_de, and checks sync delay and o_cfg_upd each cycle.
module tb_csc_nxn;

    localparam int CH = 3;
    localparam int DW = 8;
    localparam int CW = 11;
    localparam int FB = 8;
    localparam int BW = 9;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [CH*CH*CW-1:0]    i_coef;
    logic [CH*BW-1:0]       i_bias;
    logic                   i_bypass;
    logic                   i_vs, i_hs, i_de;
    logic [CH*DW-1:0]       i_x;
    logic                   o_vs, o_hs, o_de;
    logic [CH*DW-1:0]       o_y;
    logic                   o_cfg_upd;
`ifdef CSC_SAT_CNT_EN
    logic [15:0]            o_sat_cnt;
`endif

    always #5 clk = ~clk;

    csc_nxn #(
        .CH         (CH),
        .DATA_WIDTH (DW),
        .COEF_WIDTH (CW),
        .FRAC_BITS  (FB),
        .BIAS_WIDTH (BW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_coef    (i_coef),
        .i_bias    (i_bias),
        .i_bypass  (i_bypass),
        .i_vs      (i_vs),
        .i_hs      (i_hs),
        .i_de      (i_de),
        .i_x       (i_x),
        .o_vs      (o_vs),
        .o_hs      (o_hs),
        .o_de      (o_de),
        .o_y       (o_y),
        .o_cfg_upd (o_cfg_upd)
`ifdef CSC_SAT_CNT_EN
        ,
        .o_sat_cnt (o_sat_cnt)
`endif
    );

    typedef struct {
        int               stamp;
        logic [CH*DW-1:0] y;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    logic [2:0] hist [4096];
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [CH*DW-1:0] px(input int a, input int b, input int c);
        return {DW'(c), DW'(b), DW'(a)};
    endfunction

    function automatic logic [CH*CH*CW-1:0] mk_coef(input int c00, input int c01, input int c02,
                                                    input int c10, input int c11, input int c12,
                                                    input int c20, input int c21, input int c22);
        return {CW'(c22), CW'(c21), CW'(c20), CW'(c12), CW'(c11), CW'(c10), CW'(c02), CW'(c01), CW'(c00)};
    endfunction

    function automatic logic [CH*CH*CW-1:0] mk_diag(input int d);
        return mk_coef(d, 0, 0, 0, d, 0, 0, 0, d);
    endfunction

    function automatic logic [CH*BW-1:0] mk_bias(input int b0, input int b1, input int b2);
        return {BW'(b2), BW'(b1), BW'(b0)};
    endfunction

    // Input history as the DUT samples it; reset cycles record zero.
    always @(posedge clk) begin
        hist[cyc % 4096] <= rst ? 3'b000 : {i_vs, i_hs, i_de};
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!rst && cyc >= 3) begin
            logic [2:0] es;
            exp_t       e;
            es = hist[(cyc - 3) % 4096];
            check("sync_delay", {61'd0, o_vs, o_hs, o_de}, {61'd0, es});
            check("cfg_upd", {63'd0, o_cfg_upd},
                  {63'd0, hist[(cyc - 1) % 4096][2] & ~hist[(cyc - 2) % 4096][2]});
            if (o_de) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pixel", {63'd0, o_de}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("latency", 64'(cyc), 64'(e.stamp));
                    check("o_y", 64'(o_y), 64'(e.y));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pixel(input logic [CH*DW-1:0] x, input logic [CH*DW-1:0] y, input logic vs = 1'b0);
        exp_t e;
        i_vs = vs; i_hs = 1'b0; i_de = 1'b1; i_x = x;
        e.stamp = cyc + 3;
        e.y     = y;
        exp_q.push_back(e);
        step();
    endtask

    task automatic idle(input int n, input logic vs = 1'b0);
        for (int i = 0; i < n; i++) begin
            i_vs = vs; i_hs = 1'b1; i_de = 1'b0; i_x = 24'h5a5a5a;
            step();
        end
    endtask

    task automatic frame_start();
        idle(2, 1'b1);
        idle(2, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_coef = mk_diag(256); i_bias = '0; i_bypass = 1'b0;
        i_vs = 1'b0; i_hs = 1'b0; i_de = 1'b0; i_x = '0;
        rst = 1'b1;
        repeat (4) step();
        check("reset_o_y", 64'(o_y), 64'd0);
        check("reset_sync", {61'd0, o_vs, o_hs, o_de}, 64'd0);
        check("reset_cfg_upd", {63'd0, o_cfg_upd}, 64'd0);

        // Staged BT.601 set must not take effect without a vs rise.
        i_coef = mk_coef(77, 150, 29, -43, -85, 128, 128, -107, -21);
        i_bias = mk_bias(0, 128, 128);
        rst = 1'b0;
        idle(2);
        pixel(px(10, 128, 250), px(10, 128, 250));
        pixel(px(0, 255, 1), px(0, 255, 1));
        idle(3);

        // Load BT.601 and convert white, red and black.
        frame_start();
        pixel(px(255, 255, 255), px(255, 128, 128));
        pixel(px(255, 0, 0), px(77, 85, 255));
        pixel(px(0, 0, 0), px(0, 128, 128));
        // Mid-frame staging change is ignored until the next frame.
        i_coef = mk_diag(512); i_bias = mk_bias(0, 0, 0);
        pixel(px(255, 255, 255), px(255, 128, 128));
        pixel(px(0, 0, 0), px(0, 128, 128));

        // Pixel coinciding with the vs rise still uses the old set.
        pixel(px(255, 255, 255), px(255, 128, 128), 1'b1);
        idle(1, 1'b1);
        idle(2);
        pixel(px(200, 100, 127), px(255, 200, 254));
        idle(2);

        // Diagonal -1.0 clamps to zero.
        i_coef = mk_diag(-256);
        frame_start();
        pixel(px(50, 0, 1), px(0, 0, 0));
        // Bypass staged mid-frame; last three pixels still processed.
        i_bypass = 1'b1;
        pixel(px(60, 70, 80), px(0, 0, 0));
        pixel(px(90, 10, 20), px(0, 0, 0));
        pixel(px(5, 6, 7), px(0, 0, 0));
        idle(1, 1'b1);
        pixel(px(50, 0, 1), px(50, 0, 1), 1'b1);
        pixel(px(200, 100, 3), px(200, 100, 3));

        // Reset mid-frame with bypassed pixels in flight.
        i_bypass = 1'b0; i_coef = mk_diag(512);
        pixel(px(11, 22, 33), px(11, 22, 33));
        pixel(px(11, 22, 33), px(11, 22, 33));
        #3;
        rst = 1'b1;
        #1;
        check("midreset_o_y", 64'(o_y), 64'd0);
        check("midreset_sync", {61'd0, o_vs, o_hs, o_de}, 64'd0);
        check("midreset_cfg_upd", {63'd0, o_cfg_upd}, 64'd0);
`ifdef CSC_SAT_CNT_EN
        check("midreset_sat_cnt", 64'(o_sat_cnt), 64'd0);
`endif
        exp_q.delete();
        i_vs = 1'b0; i_hs = 1'b0; i_de = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        idle(2);
        pixel(px(10, 128, 250), px(10, 128, 250));
        idle(3);
        frame_start();
        pixel(px(100, 1, 200), px(200, 2, 255));
        idle(4);

`ifdef CSC_SAT_CNT_EN
        frame_start();
        check("sat_cnt_one", 64'(o_sat_cnt), 64'd1);
        for (int i = 0; i < 100; i++)
            pixel(px(200, 200, 200), px(255, 255, 255));
        idle(3);
        frame_start();
        check("sat_cnt_hundred", 64'(o_sat_cnt), 64'd100);
`endif

        idle(5);
        for (int i = 0; i < 50 && exp_q.size() > 0; i++)
            step();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
